relu_layer_sequencer: RTL and testbench
=======================================

Name: relu_layer_sequencer

Overview:
- Sequences the 32-lane RELU activation datapath.
- Accumulates a stream of 32x8-bit partial-sum beats into one sum vector, drives it onto the RELU `sumIn` bus, and pulses `trigger` for one cycle.
- Captures the 128-bit activation result and presents it downstream with a valid/ready handshake.
- Sits between the MAC array output and the next layer's input buffer.

Parameters:
- LANES, 32, number of neurons; sum bus is LANES*8 bits, activation bus is LANES*4 bits.
- MAX_BEATS, 16, maximum partial-sum beats per vector; a beat counter of clog2(MAX_BEATS)+1 bits enforces it.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- psum_in  in  LANES*8  partial-sum beat; lane i = psum_in[8i+7:8i], two's complement.
- psum_valid  in  1  beat valid.
- psum_last  in  1  marks final beat of a vector; qualified by psum_valid.
- psum_ready  out  1  beat accepted when psum_valid & psum_ready.
- relu_sumIn  out  LANES*8  to RELU sumIn.
- relu_trigger  out  1  to RELU trigger.
- relu_layer1Out  in  LANES*4  from RELU layer1Out (combinational path).
- act_out  out  LANES*4  registered activation vector.
- act_valid  out  1  act_out valid.
- act_ready  in  1  downstream accept.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (clk edge with reset=1), regardless of state:
  - state=IDLE; acc=0; beat count=0.
  - psum_ready=1, relu_trigger=0, relu_sumIn=0, act_out=0, act_valid=0, busy=0.
  - In-flight vector is discarded.
- State IDLE: psum_ready=1.
  - On an accepted beat: acc lanes load psum_in (no add), count=1.
  - If psum_last=1 -> FIRE, else -> ACCUM.
- State ACCUM: psum_ready=1.
  - Each accepted beat: acc[i] = sat8(acc[i] + lane_i). The add is a 9-bit signed add, clamped to [-128, +127]; count increments.
  - psum_last=1 -> FIRE.
  - If count reaches MAX_BEATS without psum_last, that beat is treated as last -> FIRE.
- State FIRE: exactly one cycle.
  - psum_ready=0, relu_trigger=1.
  - act_out <= relu_layer1Out at the end of the cycle -> HOLD.
- State HOLD: psum_ready=0, act_valid=1.
  - act_out is stable until act_ready=1; then act_valid=0, acc=0, count=0 -> IDLE.
  - No same-cycle acceptance of a new beat on HOLD exit.
- relu_sumIn is driven from acc at all times; relu_trigger is 1 only in FIRE. Outside FIRE the RELU outputs all-zero and is ignored.
- Expected RELU function per lane: out[4i+3]=0; out[4i+2:4i] = sum[7] ? 0 : sum[6:4]. The block relies on this only in verification; it does not recompute it.
- Latency, last beat accepted to act_valid=1: 2 cycles. Throughput: one vector per (beats + 2 + handshake wait) cycles.
- psum_valid=0 in ACCUM: state holds and acc is unchanged. There is no timeout.
- psum_last asserted without psum_valid is ignored.

Optional Feature:
- Macro: RELU_SEQ_SAT_FLAG_EN.
- Defined:
  - Adds output port sat_flag (1 bit), a sticky OR of any lane clamp during the current vector.
  - Cleared on reset and on IDLE entry.
  - Valid and stable alongside act_valid in HOLD.
- Undefined: the port does not exist and no saturation-tracking logic is present.

Test Plan:
- Single beat: all lanes 0x35, psum_last=1 -> trigger pulse 1 cycle later; act_out lanes = 4'h3; act_valid 2 cycles after accept.
- Three beats per lane: 0x10, 0x20, 0x05 (sum 0x35), then lane 0 with 0x10, 0x20, 0xC0 (sum -0x10) -> lane value 4'h3 for the first case; lane 0 = 4'h0 for the negative case.
- Saturation: two beats of 0x70 on lane 5 -> acc=0x7F, act_out lane 5 = 4'h7, sat_flag=1 when the macro is defined.
- Backpressure: act_ready=0 for 10 cycles in HOLD -> act_out stable, psum_ready=0, no beat consumed; release -> IDLE and the next beat is accepted the following cycle.
- MAX_BEATS=16 beats without psum_last -> FIRE after the 16th beat; the 17th beat is treated as the start of a new vector.
- Reset asserted mid-ACCUM (after 2 beats) -> all outputs at reset values next cycle; the following single-beat vector 0x35 yields 4'h3, with no residue from the prior acc.

Source files
------------

// File: rtl/relu_layer_sequencer.sv
// Accumulates 8-bit partial-sum beats per lane, fires the RELU datapath and holds its result for a valid/ready consumer.
// Optional macro RELU_SEQ_SAT_FLAG_EN adds a sticky per-vector saturation flag output (sat_flag).
module relu_layer_sequencer #(
  parameter int unsigned LANES     = 32,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LANES*8-1:0] psum_in,
  input  logic               psum_valid,
  input  logic               psum_last,
  output logic               psum_ready,
  output logic [LANES*8-1:0] relu_sumIn,
  output logic               relu_trigger,
  input  logic [LANES*4-1:0] relu_layer1Out,
  output logic [LANES*4-1:0] act_out,
  output logic               act_valid,
  input  logic               act_ready,
  output logic               busy
`ifdef RELU_SEQ_SAT_FLAG_EN
  ,
  output logic               sat_flag
`endif
);

  localparam int unsigned CW = $clog2(MAX_BEATS) + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, FIRE, HOLD} state_t;

  state_t             state, state_nxt;
  logic [LANES*8-1:0] acc, acc_nxt, sat_sum;
  logic [CW-1:0]      count, count_nxt;
  logic [8:0]         lane_sum;
`ifdef RELU_SEQ_SAT_FLAG_EN
  logic [LANES-1:0]   lane_clamp;
`endif

  // 9-bit signed add per lane; a mismatch of the top two bits means overflow.
  always_comb begin
    sat_sum  = '0;
    lane_sum = '0;
`ifdef RELU_SEQ_SAT_FLAG_EN
    lane_clamp = '0;
`endif
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_sum = {acc[8*i+7], acc[8*i +: 8]} + {psum_in[8*i+7], psum_in[8*i +: 8]};
      if (lane_sum[8] != lane_sum[7]) begin
        sat_sum[8*i +: 8] = lane_sum[8] ? 8'h80 : 8'h7F;
`ifdef RELU_SEQ_SAT_FLAG_EN
        lane_clamp[i] = 1'b1;
`endif
      end else begin
        sat_sum[8*i +: 8] = lane_sum[7:0];
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    acc_nxt      = acc;
    count_nxt    = count;
    psum_ready   = 1'b0;
    relu_trigger = 1'b0;
    act_valid    = 1'b0;
    case (state)
      IDLE: begin
        psum_ready = 1'b1;
        if (psum_valid) begin
          acc_nxt   = psum_in;
          count_nxt = CW'(1);
          state_nxt = psum_last ? FIRE : ACCUM;
        end
      end
      ACCUM: begin
        psum_ready = 1'b1;
        if (psum_valid) begin
          acc_nxt   = sat_sum;
          count_nxt = count + CW'(1);
          if (psum_last || count_nxt == CW'(MAX_BEATS)) state_nxt = FIRE;
        end
      end
      FIRE: begin
        relu_trigger = 1'b1;
        state_nxt    = HOLD;
      end
      HOLD: begin
        act_valid = 1'b1;
        if (act_ready) begin
          acc_nxt   = '0;
          count_nxt = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign relu_sumIn = acc;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      acc     <= '0;
      count   <= '0;
      act_out <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      count <= count_nxt;
      if (state == FIRE) act_out <= relu_layer1Out;
    end
  end

`ifdef RELU_SEQ_SAT_FLAG_EN
  // First beat is a plain load, so the flag restarts clear for every vector.
  always_ff @(posedge clk) begin
    if (reset || state == IDLE || state_nxt == IDLE) sat_flag <= 1'b0;
    else if (state == ACCUM && psum_valid)          sat_flag <= sat_flag | (|lane_clamp);
  end
`endif

endmodule

// File: tb/tb_relu_layer_sequencer.sv
// Directed self-checking bench for relu_layer_sequencer with a behavioural RELU model on the sumIn/layer1Out loop.
// Build with RELU_SEQ_SAT_FLAG_EN defined to also check sat_flag.
module tb_relu_layer_sequencer;

  localparam int unsigned LANES = 32;

  logic               clk = 1'b0;
  logic               reset;
  logic [LANES*8-1:0] psum_in;
  logic               psum_valid, psum_last, psum_ready;
  logic [LANES*8-1:0] relu_sumIn;
  logic               relu_trigger;
  logic [LANES*4-1:0] relu_layer1Out;
  logic [LANES*4-1:0] act_out;
  logic               act_valid, act_ready, busy;
`ifdef RELU_SEQ_SAT_FLAG_EN
  logic               sat_flag;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  relu_layer_sequencer #(.LANES(LANES), .MAX_BEATS(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .psum_in        (psum_in),
    .psum_valid     (psum_valid),
    .psum_last      (psum_last),
    .psum_ready     (psum_ready),
    .relu_sumIn     (relu_sumIn),
    .relu_trigger   (relu_trigger),
    .relu_layer1Out (relu_layer1Out),
    .act_out        (act_out),
    .act_valid      (act_valid),
    .act_ready      (act_ready),
    .busy           (busy)
`ifdef RELU_SEQ_SAT_FLAG_EN
    ,
    .sat_flag       (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  // RELU block: idle output is zero, triggered output is 3-bit clipped positive part.
  always_comb begin
    relu_layer1Out = '0;
    if (relu_trigger)
      for (int i = 0; i < LANES; i++)
        relu_layer1Out[4*i +: 4] = relu_sumIn[8*i+7] ? 4'h0 : {1'b0, relu_sumIn[8*i+4 +: 3]};
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [LANES*8-1:0] fill8(input logic [7:0] b);
    return {LANES{b}};
  endfunction

  function automatic logic [LANES*4-1:0] fill4(input logic [3:0] n);
    return {LANES{n}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [LANES*8-1:0] d, input logic last);
    psum_valid = 1'b1;
    psum_in    = d;
    psum_last  = last;
    tick();
    psum_valid = 1'b0;
    psum_last  = 1'b0;
  endtask

  task automatic ack();
    act_ready = 1'b1;
    tick();
    act_ready = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".psum_ready"}, 256'(psum_ready), 256'(1));
    check({tag, ".trigger"}, 256'(relu_trigger), 256'(0));
    check({tag, ".sumIn"}, 256'(relu_sumIn), 256'(0));
    check({tag, ".act_out"}, 256'(act_out), 256'(0));
    check({tag, ".act_valid"}, 256'(act_valid), 256'(0));
    check({tag, ".busy"}, 256'(busy), 256'(0));
`ifdef RELU_SEQ_SAT_FLAG_EN
    check({tag, ".sat_flag"}, 256'(sat_flag), 256'(0));
`endif
  endtask

  logic [LANES*8-1:0] v, exp_sum;
  logic [LANES*4-1:0] exp_act;

  initial begin
    reset = 1'b1; psum_in = '0; psum_valid = 1'b0; psum_last = 1'b0; act_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check_reset_vals("reset");

    // single beat 0x35
    beat(fill8(8'h35), 1'b1);
    check("t1.trigger", 256'(relu_trigger), 256'(1));
    check("t1.sumIn", 256'(relu_sumIn), 256'(fill8(8'h35)));
    check("t1.ready_fire", 256'(psum_ready), 256'(0));
    check("t1.valid_early", 256'(act_valid), 256'(0));
    tick();
    check("t1.valid", 256'(act_valid), 256'(1));
    check("t1.trigger_off", 256'(relu_trigger), 256'(0));
    check("t1.act", 256'(act_out), 256'(fill4(4'h3)));
    ack();
    check("t1.busy_after", 256'(busy), 256'(0));
    check("t1.sumIn_clr", 256'(relu_sumIn), 256'(0));

    // three beats; lane 0 ends negative (0x10+0x20+0xC0 = 0xF0)
    v = fill8(8'h10);
    beat(v, 1'b0);
    check("t2.busy", 256'(busy), 256'(1));
    check("t2.ready_accum", 256'(psum_ready), 256'(1));
    check("t2.sumIn1", 256'(relu_sumIn), 256'(fill8(8'h10)));
    beat(fill8(8'h20), 1'b0);
    v = fill8(8'h05); v[7:0] = 8'hC0;
    beat(v, 1'b1);
    exp_sum = fill8(8'h35); exp_sum[7:0] = 8'hF0;
    check("t2.sumIn", 256'(relu_sumIn), 256'(exp_sum));
    check("t2.trigger", 256'(relu_trigger), 256'(1));
    tick();
    exp_act = fill4(4'h3); exp_act[3:0] = 4'h0;
    check("t2.act", 256'(act_out), 256'(exp_act));
`ifdef RELU_SEQ_SAT_FLAG_EN
    check("t2.sat_flag", 256'(sat_flag), 256'(0));
`endif
    ack();

    // saturation: lane 5 clamps to 0x7F, lane 6 clamps to 0x80, others 0x02
    v = fill8(8'h01); v[8*5 +: 8] = 8'h70; v[8*6 +: 8] = 8'h90;
    beat(v, 1'b0);
    beat(v, 1'b1);
    exp_sum = fill8(8'h02); exp_sum[8*5 +: 8] = 8'h7F; exp_sum[8*6 +: 8] = 8'h80;
    check("t3.sumIn", 256'(relu_sumIn), 256'(exp_sum));
    tick();
    exp_act = '0; exp_act[4*5 +: 4] = 4'h7;
    check("t3.act", 256'(act_out), 256'(exp_act));
`ifdef RELU_SEQ_SAT_FLAG_EN
    check("t3.sat_flag", 256'(sat_flag), 256'(1));
`endif
    ack();
`ifdef RELU_SEQ_SAT_FLAG_EN
    check("t3.sat_flag_clr", 256'(sat_flag), 256'(0));
`endif

    // backpressure in HOLD with a beat waiting
    beat(fill8(8'h35), 1'b1);
    tick();
    psum_valid = 1'b1; psum_in = fill8(8'h77); psum_last = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("t4.act_stable", 256'(act_out), 256'(fill4(4'h3)));
      check("t4.ready_hold", 256'(psum_ready), 256'(0));
      check("t4.valid_hold", 256'(act_valid), 256'(1));
      check("t4.sumIn_hold", 256'(relu_sumIn), 256'(fill8(8'h35)));
    end
    ack();
    check("t4.idle", 256'(busy), 256'(0));
    check("t4.no_same_cycle", 256'(relu_sumIn), 256'(0));
    tick();
    psum_valid = 1'b0; psum_last = 1'b0;
    check("t4.next_trigger", 256'(relu_trigger), 256'(1));
    check("t4.next_sumIn", 256'(relu_sumIn), 256'(fill8(8'h77)));
    tick();
    check("t4.next_act", 256'(act_out), 256'(fill4(4'h7)));
    ack();

    // 16 beats without psum_last force FIRE
    for (int b = 0; b < 15; b++) beat(fill8(8'h01), 1'b0);
    check("t5.b15_trigger", 256'(relu_trigger), 256'(0));
    check("t5.b15_ready", 256'(psum_ready), 256'(1));
    beat(fill8(8'h01), 1'b0);
    check("t5.b16_trigger", 256'(relu_trigger), 256'(1));
    check("t5.b16_sumIn", 256'(relu_sumIn), 256'(fill8(8'h10)));
    tick();
    check("t5.act", 256'(act_out), 256'(fill4(4'h1)));
    ack();
    beat(fill8(8'h35), 1'b0);
    check("t5.b17_load", 256'(relu_sumIn), 256'(fill8(8'h35)));
    check("t5.b17_busy", 256'(busy), 256'(1));
    check("t5.b17_trigger", 256'(relu_trigger), 256'(0));
    beat(fill8(8'h00), 1'b1);
    check("t5.v2_sumIn", 256'(relu_sumIn), 256'(fill8(8'h35)));
    tick();
    check("t5.v2_act", 256'(act_out), 256'(fill4(4'h3)));
    ack();

    // reset mid-ACCUM after two beats (0x40+0x40 clamps to 0x7F)
    beat(fill8(8'h40), 1'b0);
    beat(fill8(8'h40), 1'b0);
    check("t6.sumIn_pre", 256'(relu_sumIn), 256'(fill8(8'h7F)));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_vals("t6.reset");
    beat(fill8(8'h35), 1'b1);
    check("t6.sumIn", 256'(relu_sumIn), 256'(fill8(8'h35)));
    tick();
    check("t6.act", 256'(act_out), 256'(fill4(4'h3)));
    ack();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
